// File: rtl/div3_scan_ctrl.sv
// div3_scan_ctrl: walks an inclusive packed-BCD range one candidate per
// cycle and hands every multiple of 3 downstream through a valid/ready
// output. The candidate counter increments in decimal directly, so there is
// no binary<->BCD conversion anywhere on the datapath.
module div3_scan_ctrl #(
    parameter int HIT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      start_bcd,
    input  logic [15:0]      end_bcd,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [15:0]      out_bcd,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [HIT_W-1:0] hit_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [15:0]      r_cur;
    logic [15:0]      r_end;
    logic             r_out_valid;
    logic [15:0]      r_out_bcd;
    logic             r_err;
    logic [HIT_W-1:0] r_hit;

    logic             w_start_ok;
    logic             w_start_bad;
    logic             w_div;
    logic             w_at_end;
    logic             w_hs;
    logic [15:0]      w_cur_inc;
    logic [5:0]       w_digit_sum;

    // True when every nibble of v is a legal decimal digit.
    function automatic logic f_bcd_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Decimal ripple increment: a 9 wraps to 0 and carries into the next digit.
    function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // With all digits legal, packed-BCD magnitude order equals binary order,
    // so a plain unsigned compare is enough for the range check.
    assign w_start_ok  = f_bcd_ok(start_bcd) && f_bcd_ok(end_bcd) &&
                         (start_bcd <= end_bcd);
    assign w_start_bad = !w_start_ok;

    // Digit-sum test for divisibility by 3; the sum tops out at 36.
    assign w_digit_sum = {2'b00, r_cur[15:12]} + {2'b00, r_cur[11:8]} +
                         {2'b00, r_cur[7:4]}   + {2'b00, r_cur[3:0]};
    assign w_div       = ((w_digit_sum % 6'd3) == 6'd0);

    assign w_at_end    = (r_cur == r_end);
    assign w_hs        = r_out_valid && out_ready;
    assign w_cur_inc   = f_bcd_inc(r_cur);

    // Next-state decode; the end check always precedes the increment so the
    // counter never wraps past the last candidate.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && w_start_ok) w_state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (w_div)         w_state_nxt = S_EMIT;
                else if (w_at_end) w_state_nxt = S_DONE;
            end
            S_EMIT: begin
                if (w_hs) w_state_nxt = w_at_end ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset drops straight to IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Candidate register: loaded on an accepted start, stepped after each
    // non-final candidate is either rejected or handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: if (start && w_start_ok) r_cur <= start_bcd;
                S_SCAN: if (!w_div && !w_at_end) r_cur <= w_cur_inc;
                S_EMIT: if (w_hs && !w_at_end)   r_cur <= w_cur_inc;
                default: ;
            endcase
        end
    end

    // End bound is captured at start so input changes mid-scan are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_end <= 16'h0000;
        end else if (r_state == S_IDLE && start && w_start_ok) begin
            r_end <= end_bcd;
        end
    end

    // Output register: out_bcd only changes when a new hit is presented, so it
    // keeps the last hit while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_bcd   <= 16'h0000;
        end else if (r_state == S_SCAN && w_div) begin
            r_out_valid <= 1'b1;
            r_out_bcd   <= r_cur;
        end else if (r_state == S_EMIT && w_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    // Hit counter: cleared on accepted start, bumped once per handshake,
    // otherwise held so the last scan's total stays readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit <= '0;
        end else if (r_state == S_IDLE && start && w_start_ok) begin
            r_hit <= '0;
        end else if (r_state == S_EMIT && w_hs) begin
            r_hit <= r_hit + HIT_W'(1);
        end
    end

    // Reject pulse for a malformed or inverted range; starts outside IDLE
    // are dropped silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= (r_state == S_IDLE) && start && w_start_bad;
    end

    assign out_valid = r_out_valid;
    assign out_bcd   = r_out_bcd;
    assign hit_count = r_hit;
    assign busy      = (r_state == S_SCAN) || (r_state == S_EMIT);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_div3_scan_ctrl.sv
// Bench for div3_scan_ctrl: a table of ranges replayed through one scan task,
// an integer reference model feeding an expected-output queue, and a
// negedge monitor that pops on each handshake and checks stall stability.
module tb_div3_scan_ctrl;

    localparam int HIT_W = 14;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [15:0]      start_bcd = 16'h0000;
    logic [15:0]      end_bcd = 16'h0000;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [15:0]      out_bcd;
    logic             busy;
    logic             done;
    logic             err;
    logic [HIT_W-1:0] hit_count;

    div3_scan_ctrl #(.HIT_W(HIT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_bcd(start_bcd),
        .end_bcd(end_bcd), .out_ready(out_ready), .out_valid(out_valid),
        .out_bcd(out_bcd), .busy(busy), .done(done), .err(err),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s;
        logic [15:0] e;
        int          stall;     // ready-low cycles per emitted value
        bit          bad;       // start must be rejected with err
        bit          poke;      // fire a stray start mid-scan
        int          exp_hits;
        logic [15:0] exp_last;  // out_bcd expected once the scan ends
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic        p_vld = 1'b0;
    logic        p_rdy = 1'b0;
    logic [15:0] p_bcd = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Scoreboard pop on every accepted value, plus hold checks during stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            if (p_vld && !p_rdy) begin
                chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
                chk("stall_bcd_hold", {16'd0, out_bcd}, {16'd0, p_bcd});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %04h, expected no output at %0t", out_bcd, $time);
                end else begin
                    chk("out_bcd", {16'd0, out_bcd}, {16'd0, exp_q.pop_front()});
                end
            end
        end
        p_vld <= out_valid && rst_n;
        p_rdy <= out_ready;
        p_bcd <= out_bcd;
    end

    task automatic run_scan(input vec_t v);
        int               k;
        int               n;
        int               h;
        int               wcnt;
        int               errs;
        int               bound;
        logic [HIT_W-1:0] hit_before;
        n = 0; h = 0; wcnt = 0; errs = 0;
        if (!v.bad) begin
            for (int i = bcd2int(v.s); i <= bcd2int(v.e); i++) begin
                n++;
                if (i % 3 == 0) begin
                    h++;
                    exp_q.push_back(int2bcd(i));
                end
            end
        end
        hit_before = hit_count;
        out_ready  = (v.stall == 0);
        start      = 1'b1;
        start_bcd  = v.s;
        end_bcd    = v.e;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_bcd = 16'h9999;
        end_bcd   = 16'h0000;
        if (v.bad) begin
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_stays_idle", {31'd0, busy}, 32'd0);
            @(posedge clk);
            #1;
            chk("err_one_cycle", {31'd0, err}, 32'd0);
            chk("err_still_idle", {31'd0, busy}, 32'd0);
            chk("err_hit_hold", 32'(hit_count), 32'(hit_before));
            return;
        end
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("hit_cleared", 32'(hit_count), 32'd0);
        bound = n + h * (v.stall + 2) + 20;
        k = 0;
        while (!done && k < bound) begin
            @(posedge clk);
            k++;
            #1;
            if (err) errs++;
            if (v.stall > 0) begin
                if (out_ready) begin
                    out_ready = 1'b0;
                    wcnt = 0;
                end else if (out_valid) begin
                    if (wcnt == v.stall) out_ready = 1'b1;
                    else wcnt++;
                end
            end
            if (v.poke && k == 3) begin
                start = 1'b1; start_bcd = 16'h0001; end_bcd = 16'h0002;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles for %04h-%04h", bound, v.s, v.e);
        end else if (v.stall == 0) begin
            chk("done_latency", 32'(k + 1), 32'(n + h + 1));
        end
        chk("hit_count", 32'(hit_count), 32'(v.exp_hits));
        chk("last_out_bcd", {16'd0, out_bcd}, {16'd0, v.exp_last});
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("no_err_in_scan", 32'(errs), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
        chk("hit_hold_idle", 32'(hit_count), 32'(v.exp_hits));
        out_ready = 1'b0;
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        tbl[0] = '{16'h0000, 16'h0010, 0, 1'b0, 1'b0,    4, 16'h0009};
        tbl[1] = '{16'h0096, 16'h0102, 5, 1'b0, 1'b0,    3, 16'h0102};
        tbl[2] = '{16'h00A0, 16'h0100, 0, 1'b1, 1'b0,    0, 16'h0000};
        tbl[3] = '{16'h0050, 16'h0040, 0, 1'b1, 1'b0,    0, 16'h0000};
        tbl[4] = '{16'h0000, 16'h00F0, 0, 1'b1, 1'b0,    0, 16'h0000};
        tbl[5] = '{16'h0007, 16'h0007, 0, 1'b0, 1'b0,    0, 16'h0102};
        tbl[6] = '{16'h0123, 16'h0150, 2, 1'b0, 1'b0,   10, 16'h0150};
        tbl[7] = '{16'h0990, 16'h1010, 0, 1'b0, 1'b0,    7, 16'h1008};
        tbl[8] = '{16'h0000, 16'h0020, 0, 1'b0, 1'b1,    7, 16'h0018};
        tbl[9] = '{16'h0000, 16'h9999, 0, 1'b0, 1'b0, 3334, 16'h9999};

        // Reset state, checked before any clock edge.
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_bcd", {16'd0, out_bcd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_hit", 32'(hit_count), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 10; t++) run_scan(tbl[t]);

        // Reset while 0012 is stalled in EMIT.
        out_ready = 1'b0;
        start = 1'b1; start_bcd = 16'h0010; end_bcd = 16'h0020;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        chk("emit_0012_valid", {31'd0, out_valid}, 32'd1);
        chk("emit_0012_bcd", {16'd0, out_bcd}, 32'h0012);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_bcd", {16'd0, out_bcd}, 32'd0);
        chk("async_rst_hit", 32'(hit_count), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("rst_no_done", {31'd0, done}, 32'd0);
            chk("rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rv = '{16'h0012, 16'h0012, 0, 1'b0, 1'b0, 1, 16'h0012};
        run_scan(rv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div3_scan_ctrl.md
DIV3_SCAN_CTRL -- requirements
Module: div3_scan_ctrl

Interface
REQ-001 Parameter: HIT_W, default 14, width of hit_count; must be >= 12, and 14 covers the full 0000-9999 range (3334 hits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
REQ-005 start_bcd  input  16  first candidate, 4 packed BCD digits, [15:12] most significant.
REQ-006 end_bcd  input  16  last candidate, inclusive, same packing.
REQ-007 out_ready  input  1  downstream accepts out_bcd when high with out_valid.
REQ-008 out_valid  output  1  out_bcd holds a multiple of 3 awaiting acceptance.
REQ-009 out_bcd  output  16  current multiple-of-3 candidate, packed BCD.
REQ-010 busy  output  1  high in SCAN and EMIT.
REQ-011 done  output  1  one-cycle pulse when a scan completes.
REQ-012 err  output  1  one-cycle pulse when a start request is rejected.
REQ-013 hit_count  output  HIT_W  number of values accepted in the current or last scan.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SCAN, EMIT and DONE.
REQ-015 Divisibility SHALL be decided combinationally on the internal candidate register cur, as (sum of the 4 digits) mod 3 == 0; 0000 counts as divisible.
REQ-016 In IDLE, start=1 with all 8 digits <= 9 and start_bcd <= end_bcd SHALL load cur=start_bcd, clear hit_count and enter SCAN on the next edge.
REQ-017 In IDLE, start=1 with any digit > 9 or start_bcd > end_bcd SHALL pulse err for one cycle, stay in IDLE and leave hit_count unchanged.
REQ-018 In SCAN, one candidate SHALL be evaluated per cycle.
REQ-019 In SCAN, if cur is divisible, the FSM SHALL enter EMIT with out_valid=1 and out_bcd=cur registered on the same edge.
REQ-020 In SCAN, if cur is not divisible and cur==end_val, the FSM SHALL enter DONE; otherwise it SHALL apply a BCD increment to cur and stay in SCAN.
REQ-021 end_val SHALL be a copy of end_bcd latched at start; changes to the inputs during a scan SHALL have no effect.
REQ-022 In EMIT, out_valid and out_bcd SHALL hold stable until out_valid & out_ready is sampled high.
REQ-023 On the EMIT handshake, hit_count SHALL increment and out_valid SHALL drop; the FSM SHALL then enter DONE if cur==end_val, else apply a BCD increment to cur and enter SCAN.
REQ-024 The BCD increment SHALL be a decimal ripple: a digit at 9 becomes 0 and carries, so 0099 -> 0100 and 0999 -> 1000.
REQ-025 9999 SHALL never be incremented, since the end check precedes the increment.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-027 hit_count SHALL hold its value through DONE and IDLE until the next accepted start.
REQ-028 start asserted in SCAN, EMIT or DONE SHALL be ignored; it SHALL NOT be queued and SHALL NOT raise err.
REQ-029 busy SHALL be 1 exactly when the state is SCAN or EMIT.
REQ-030 out_bcd SHALL keep its last value when out_valid=0.
REQ-031 Latency: with out_ready tied high, a range of N candidates containing H multiples SHALL assert done N+H+1 cycles after the start edge.

Reset
REQ-032 When rst_n=0, the state SHALL become IDLE immediately, independent of clk.
REQ-033 Reset SHALL clear out_valid, done, err, busy, hit_count, out_bcd, cur and end_val to 0.
REQ-034 Reset asserted mid-scan SHALL abort the scan with no done pulse and no further handshakes.
REQ-035 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-036 start_bcd=0000, end_bcd=0010, out_ready=1 -> out_bcd sequence 0000, 0003, 0006, 0009; done pulses; hit_count=4.
REQ-037 Range 0096-0102 with out_ready low for 5 cycles per emit -> 0096, 0099, 0102 each held stable until accepted; carries 0099->0100 correct; hit_count=3.
REQ-038 start_bcd=end_bcd=0007 -> no out_valid; done 2 cycles after the start edge; hit_count=0.
REQ-039 start_bcd=00A0 -> err pulse, state stays IDLE. Separately, start_bcd=0050 with end_bcd=0040 -> err pulse, hit_count unchanged.
REQ-040 Range 0000-9999, out_ready=1 -> hit_count=3334; last out_bcd=9999; no wrap past 9999.
REQ-041 rst_n low during EMIT of 0012 -> out_valid=0 and busy=0 immediately; no done pulse. A new start 0012-0012 then emits 0012 with hit_count=1.
